// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU, one operation per valid/ready transaction.
// Latency: single-step, illegal and zero-shift ops finish 0 cycles after accept; shifts take shamt cycles; MULU takes WIDTH cycles.
// Backpressure: the result and flags are held in DONE until outReady, and no new accept happens until then.
//
// Ports: clk/reset (async active-high); A, B, opcode, inputCarry, inValid/inReady request side;
//        out plus negative/zero/carry/overflow/error flags, outValid/outReady result side.
// Optional feature: define ALU_SEQ_MUL_EN to compile in the shift-add multiplier (opcode 001111).
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       opcode,
  input  logic             inputCarry,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] out,
  output logic             negativeFlag,
  output logic             zeroFlag,
  output logic             carryFlag,
  output logic             overflowFlag,
  output logic             errorFlag,
  output logic             outValid,
  input  logic             outReady
);

  localparam int CW  = $clog2(WIDTH) + 1;  // must hold WIDTH for the multiply step count
  localparam int MSB = WIDTH - 1;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDU = 6'b000101;
  localparam logic [5:0] OP_ADDC = 6'b010000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_SUBU = 6'b001101;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_XOR  = 6'b000100;
  localparam logic [5:0] OP_NOR  = 6'b001001;
  localparam logic [5:0] OP_SLL  = 6'b000110;
  localparam logic [5:0] OP_SRL  = 6'b000111;
  localparam logic [5:0] OP_SRA  = 6'b001110;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [5:0] OP_MULU = 6'b001111;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef ALU_SEQ_MUL_EN
    , MUL = 2'd3
`endif
  } state_t;

  state_t state, state_d;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic [WIDTH:0]   sum_w, sumc_w, diff_w;
  logic [WIDTH-1:0] ss_res;
  logic             ss_c, ss_v, ss_err;

  logic [WIDTH-1:0] sh, sh_next;
  logic [1:0]       sh_kind;   // 0 SLL, 1 SRL, 2 SRA
  logic [CW-1:0]    cnt;

  logic             load;
  logic [WIDTH-1:0] res_d;
  logic             c_d, v_d, e_d;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [WIDTH-1:0]   mplier;
  assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

  assign inReady  = (state == IDLE) && !reset;
  assign outValid = (state == DONE);
  assign accept   = inValid && inReady;
  assign shamt    = B[SHW-1:0];
  assign is_shift = (opcode == OP_SLL) || (opcode == OP_SRL) || (opcode == OP_SRA);

  // Zero-extended WIDTH+1 arithmetic: the top bit is carry-out for sums and borrow (A<B) for the difference.
  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign sumc_w = sum_w + {{WIDTH{1'b0}}, inputCarry};
  assign diff_w = {1'b0, A} - {1'b0, B};

  always_comb begin
    ss_res = '0;
    ss_c   = 1'b0;
    ss_v   = 1'b0;
    ss_err = 1'b0;
    case (opcode)
      OP_ADD: begin
        ss_res = sum_w[WIDTH-1:0];
        ss_c   = sum_w[WIDTH];
        ss_v   = (A[MSB] == B[MSB]) && (sum_w[MSB] != A[MSB]);
      end
      OP_ADDU: begin
        ss_res = sum_w[WIDTH-1:0];
        ss_c   = sum_w[WIDTH];
      end
      OP_ADDC: begin
        ss_res = sumc_w[WIDTH-1:0];
        ss_c   = sumc_w[WIDTH];
        ss_v   = (A[MSB] == B[MSB]) && (sumc_w[MSB] != A[MSB]);
      end
      OP_SUB: begin
        ss_res = diff_w[WIDTH-1:0];
        ss_c   = diff_w[WIDTH];
        ss_v   = (A[MSB] != B[MSB]) && (diff_w[MSB] != A[MSB]);
      end
      OP_SUBU: begin
        ss_res = diff_w[WIDTH-1:0];
        ss_c   = diff_w[WIDTH];
      end
      OP_AND: ss_res = A & B;
      OP_OR:  ss_res = A | B;
      OP_XOR: ss_res = A ^ B;
      OP_NOR: ss_res = ~(A | B);
      // Shifts only complete straight from IDLE when shamt is zero, so the result is A.
      OP_SLL, OP_SRL, OP_SRA: ss_res = A;
`ifdef ALU_SEQ_MUL_EN
      OP_MULU: ss_res = '0;
`endif
      default: ss_err = 1'b1;
    endcase
  end

  always_comb begin
    sh_next = '0;
    case (sh_kind)
      2'd0:    sh_next = sh << 1;
      2'd1:    sh_next = sh >> 1;
      default: sh_next = {sh[MSB], sh[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // The step that brings cnt from 1 to 0 is the last one, so its result goes straight into out.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    res_d   = ss_res;
    c_d     = ss_c;
    v_d     = ss_v;
    e_d     = ss_err;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) state_d = SHIFT;
`ifdef ALU_SEQ_MUL_EN
          else if (opcode == OP_MULU) state_d = MUL;
`endif
          else begin
            state_d = DONE;
            load    = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cnt == CW'(1)) begin
          state_d = DONE;
          load    = 1'b1;
          res_d   = sh_next;
          c_d     = 1'b0;
          v_d     = 1'b0;
          e_d     = 1'b0;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        if (cnt == CW'(1)) begin
          state_d = DONE;
          load    = 1'b1;
          res_d   = acc_next[WIDTH-1:0];
          c_d     = |acc_next[2*WIDTH-1:WIDTH];
          v_d     = 1'b0;
          e_d     = 1'b0;
        end
      end
`endif
      DONE: begin
        if (outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out          <= '0;
      negativeFlag <= 1'b0;
      zeroFlag     <= 1'b0;
      carryFlag    <= 1'b0;
      overflowFlag <= 1'b0;
      errorFlag    <= 1'b0;
      sh           <= '0;
      sh_kind      <= 2'd0;
      cnt          <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
`endif
    end else begin
      if (accept) begin
        sh      <= A;
        cnt     <= CW'(shamt);
        sh_kind <= (opcode == OP_SLL) ? 2'd0 : (opcode == OP_SRL) ? 2'd1 : 2'd2;
`ifdef ALU_SEQ_MUL_EN
        if (opcode == OP_MULU) cnt <= CW'(WIDTH);
        mcand  <= {{WIDTH{1'b0}}, A};
        mplier <= B;
        acc    <= '0;
`endif
      end
      if (state == SHIFT) begin
        sh  <= sh_next;
        cnt <= cnt - CW'(1);
      end
`ifdef ALU_SEQ_MUL_EN
      if (state == MUL) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        acc    <= acc_next;
        cnt    <= cnt - CW'(1);
      end
`endif
      if (load) begin
        out          <= res_d;
        negativeFlag <= res_d[MSB];
        zeroFlag     <= (res_d == '0);
        carryFlag    <= c_d;
        overflowFlag <= v_d;
        errorFlag    <= e_d;
      end
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the datapath's combinational ALU. It accepts one operation per transaction over a valid/ready handshake, executes single-step ops in one cycle, shifts one bit per cycle and unsigned multiply by shift-add. It holds result and registered flags until the consumer takes them. It sits between operand fetch and writeback in the execute stage.

## Interface
- `WIDTH`, default 32: operand/result width, power of two, ≥8
- `SHW`, default $clog2(WIDTH): shift-amount bits taken from B
- `clk` input 1: clock, rising edge
- `reset` input 1: asynchronous, active-high
- `A`, `B` input WIDTH: operands, captured on accept
- `opcode` input 6: operation, captured on accept
- `inputCarry` input 1: carry-in for ADDC, captured on accept
- `inValid` input 1: request valid
- `inReady` output 1: block can accept; accept = inValid && inReady at a rising edge
- `out` output WIDTH: registered result
- `negativeFlag`, `zeroFlag`, `carryFlag`, `overflowFlag`, `errorFlag` output 1 each: registered flags for `out`
- `outValid` output 1: result valid
- `outReady` input 1: consumer takes result; complete = outValid && outReady at a rising edge

## Operation
- Opcodes: 000000 ADD, 000101 ADDU, 010000 ADDC, 000001 SUB, 001101 SUBU, 000010 AND, 000011 OR, 000100 XOR, 001001 NOR, 000110 SLL, 000111 SRL, 001110 SRA, 001111 MULU. Any other opcode is illegal.
- States: IDLE, SHIFT, MUL, DONE.
  - IDLE→DONE on accept for single-step ops, illegal opcodes, and shifts with shamt=0.
  - IDLE→SHIFT on a shift with shamt≠0.
  - IDLE→MUL on MULU.
  - SHIFT→DONE when its count reaches 0. MUL→DONE after WIDTH steps.
  - DONE→IDLE on complete.
- `inReady` = (state==IDLE) && !reset. No new accept while busy or in DONE.
- shamt = B[SHW-1:0]. Upper bits of B are ignored for shifts.
- SHIFT: one bit per cycle. SRA replicates the MSB.
- MULU: one B bit per cycle, with a 2·WIDTH accumulator.
  - out = low WIDTH bits.
  - carryFlag = 1 if any high-half bit is nonzero.
- Arithmetic is unsigned WIDTH+1-bit.
  - ADD, ADDU: carryFlag = carry-out.
  - ADDC: A+B+inputCarry, carryFlag = carry-out.
  - SUB, SUBU: A−B, carryFlag = borrow (A<B unsigned).
- overflowFlag:
  - ADD, ADDC: A[MSB]==B[MSB] && out[MSB]!=A[MSB].
  - SUB: A[MSB]!=B[MSB] && out[MSB]!=A[MSB].
  - 0 for all other ops.
- carryFlag = 0 for logic and shift ops.
- negativeFlag = out[MSB]; zeroFlag = (out==0). Both are valid for every op.
- Illegal opcode: out=0, errorFlag=1, zeroFlag=1, all other flags 0. errorFlag=0 for legal ops.
- `out` and the flags are updated only on entry to DONE. They hold stable while outValid=1, and they also hold after complete until the next result.

## Timing
- Reset (async, any state):
  - state=IDLE, out=0, all flags 0, outValid=0, internal counters cleared.
  - inReady=0 while reset is high and 1 from the first cycle after release.
  - An in-flight operation is discarded, with no result.
- With accept at edge k, outValid is high after edge k+N:
  - N=0 for single-step and illegal ops.
  - N=shamt for shifts (0..WIDTH−1).
  - N=WIDTH for MULU.
- outValid stays high until complete. outReady is ignored while outValid=0.
- On complete at edge j: outValid=0 and inReady=1 after edge j, so the next accept is possible at edge j+1 at the earliest.
- Back-to-back single-step throughput is one result per 2 cycles when outReady is held high.
- Changes to inputs while busy have no effect on the operation in flight.

## Configuration
- `ALU_SEQ_MUL_EN`:
  - Defined: the MUL state, the accumulator and opcode 001111 are compiled in.
  - Undefined: 001111 is an illegal opcode (1-cycle, errorFlag=1), and no multiplier logic is present.

## Test plan
- Reset mid-MULU (WIDTH=32, accept then reset at step 5) → outValid=0, out=0, flags 0; after release inReady=1 and the next ADD 6+10 returns 16 with N=0.
- ADD 0x7FFFFFFF+1 → out=0x80000000, overflowFlag=1, negativeFlag=1, carryFlag=0. SUB 0x80000000−1 → 0x7FFFFFFF, overflowFlag=1. SUBU 5−6 → 0xFFFFFFFF, carryFlag=1, overflowFlag=0.
- SRA A=0x80000000 B=31 → outValid after edge k+31, out=0xFFFFFFFF. SLL with B=0x20 (shamt=0) → out=A at N=0.
- MULU 0x10000×0x10000, with the macro defined → outValid after edge k+32, out=0, carryFlag=1, zeroFlag=1. With the macro undefined → errorFlag=1 at N=0.
- outReady held low for 10 cycles after an AND result → out and flags stable, inReady=0, and an inValid pulse is ignored. Illegal opcode 111111 → out=0, errorFlag=1.
- ADDC 0xFFFFFFFF+0+inputCarry=1 → out=0, carryFlag=1, zeroFlag=1.
